// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : usb_pkg
// Brief    : Line-state and receiver FSM encodings, status/err_code constants.
// Revision : 1.0 - initial release
// ============================================================================
package usb_pkg;

  // Encoded as {d_p, d_n}
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_EOP  = 3'd3,
    ST_ERR  = 3'd4
  } rx_state_t;

  localparam logic [1:0] c_STATUS_IDLE = 2'b00;
  localparam logic [1:0] c_STATUS_RX   = 2'b01;
  localparam logic [1:0] c_STATUS_OK   = 2'b10;
  localparam logic [1:0] c_STATUS_ERR  = 2'b11;

  localparam logic [1:0] c_ERR_NONE  = 2'b00;
  localparam logic [1:0] c_ERR_STUFF = 2'b01;
  localparam logic [1:0] c_ERR_OVF   = 2'b10;
  localparam logic [1:0] c_ERR_FRAME = 2'b11;

  function automatic line_state_t line_decode(input logic dp, input logic dn);
    return line_state_t'({dp, dn});
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_fifo
// Brief    : Word FIFO with flush; push into a full FIFO succeeds only with a pop.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_DEPTH);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign overflow  = push & full & ~w_do_pop;
  // Gated so the output reads zero whenever nothing is held
  assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/usb_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_decoder
// Brief    : Oversampled USB receiver: sync, NRZI decode, destuff, word FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_decoder #(
  parameter int OVERSAMPLE = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_p,
  input  logic              d_n,
  input  logic              vbus,
  input  logic              rx_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [1:0]        status,
  output logic [1:0]        err_code,
  output logic              eop
);

  import usb_pkg::*;

  localparam int c_PH_W  = $clog2(OVERSAMPLE);
  localparam int c_CNT_W = $clog2(DATA_W);
  localparam logic [c_PH_W-1:0]  c_PH_SAMPLE = c_PH_W'(OVERSAMPLE/2 - 1);
  localparam logic [c_PH_W-1:0]  c_PH_LAST   = c_PH_W'(OVERSAMPLE - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DATA_W - 1);
  localparam logic [c_CNT_W-1:0] c_SYNC_LAST = c_CNT_W'(7);
  localparam logic [2:0]         c_STUFF_RUN = 3'd6;

  logic [1:0]         r_dp_sync, r_dn_sync, r_vbus_sync;
  logic               r_dp_prev;
  logic [c_PH_W-1:0]  r_phase;
  rx_state_t          r_state, w_state_nxt;
  line_state_t        r_prev_line, w_line;
  logic [1:0]         r_status, r_err;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_ones;
  logic [DATA_W-1:0]  r_shift;
  logic               r_push, r_eop, r_eop_seen;

  logic w_dp_edge, w_sample, w_rx_on, w_bit, w_line_jk;
  logic w_sync_enter, w_sync_bit, w_data_enter, w_bit_take, w_stuff_skip;
  logic w_eop_hit, w_err_hit;
  logic [1:0] w_err_val;
  logic w_pop, w_full, w_empty, w_fifo_ovf, w_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dp_sync   <= '0;
      r_dn_sync   <= '0;
      r_vbus_sync <= '0;
      r_dp_prev   <= 1'b0;
      r_phase     <= '0;
    end else begin
      r_dp_sync   <= {r_dp_sync[0], d_p};
      r_dn_sync   <= {r_dn_sync[0], d_n};
      r_vbus_sync <= {r_vbus_sync[0], vbus};
      r_dp_prev   <= r_dp_sync[1];
      // Every d_p edge realigns the bit clock
      if (w_dp_edge || r_phase == c_PH_LAST) r_phase <= '0;
      else                                   r_phase <= r_phase + 1'b1;
    end
  end

  assign w_dp_edge = r_dp_sync[1] ^ r_dp_prev;
  assign w_sample  = (r_phase == c_PH_SAMPLE);
  assign w_line    = line_decode(r_dp_sync[1], r_dn_sync[1]);
  assign w_line_jk = (w_line == LINE_J) || (w_line == LINE_K);
  assign w_bit     = (w_line == r_prev_line);
  assign w_rx_on   = r_vbus_sync[1] & rx_en;
  assign w_flush   = ~w_rx_on;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // The entering K is the first SYNC bit, so SYNC starts with one 0 counted.
  always_comb begin
    w_state_nxt  = r_state;
    w_sync_enter = 1'b0;
    w_sync_bit   = 1'b0;
    w_data_enter = 1'b0;
    w_bit_take   = 1'b0;
    w_stuff_skip = 1'b0;
    w_eop_hit    = 1'b0;
    w_err_hit    = 1'b0;
    w_err_val    = c_ERR_NONE;
    if (!w_rx_on) begin
      w_state_nxt = ST_IDLE;
    end else if (w_sample) begin
      case (r_state)
        ST_IDLE: begin
          if (w_line == LINE_K) begin
            w_state_nxt  = ST_SYNC;
            w_sync_enter = 1'b1;
          end
        end
        ST_SYNC: begin
          if (!w_line_jk || (w_bit != (r_cnt == c_SYNC_LAST))) begin
            w_err_hit = 1'b1;
            w_err_val = c_ERR_FRAME;
          end else begin
            w_sync_bit = 1'b1;
            if (r_cnt == c_SYNC_LAST) begin
              w_state_nxt  = ST_DATA;
              w_data_enter = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_line == LINE_SE1) begin
            w_err_hit = 1'b1;
            w_err_val = c_ERR_FRAME;
          end else if (w_line == LINE_SE0) begin
            w_state_nxt = ST_EOP;
          end else if (r_ones == c_STUFF_RUN) begin
            if (w_bit) begin
              w_err_hit = 1'b1;
              w_err_val = c_ERR_STUFF;
            end else begin
              w_stuff_skip = 1'b1;
            end
          end else begin
            w_bit_take = 1'b1;
          end
        end
        ST_EOP: begin
          if (!r_eop_seen) begin
            if (w_line == LINE_SE0) begin
              w_eop_hit = 1'b1;
            end else begin
              w_err_hit = 1'b1;
              w_err_val = c_ERR_FRAME;
            end
          end else if (w_line == LINE_J) begin
            w_state_nxt = ST_IDLE;
          end else if (w_line != LINE_SE0) begin
            w_err_hit = 1'b1;
            w_err_val = c_ERR_FRAME;
          end
        end
        ST_ERR: begin
          if (w_line == LINE_J) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      if (w_err_hit) w_state_nxt = ST_ERR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status    <= c_STATUS_IDLE;
      r_err       <= c_ERR_NONE;
      r_cnt       <= '0;
      r_ones      <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_eop       <= 1'b0;
      r_eop_seen  <= 1'b0;
      r_prev_line <= LINE_SE0;
    end else if (!w_rx_on) begin
      r_status    <= c_STATUS_IDLE;
      r_err       <= c_ERR_NONE;
      r_cnt       <= '0;
      r_ones      <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_eop       <= 1'b0;
      r_eop_seen  <= 1'b0;
      r_prev_line <= LINE_SE0;
    end else begin
      r_push <= 1'b0;
      r_eop  <= 1'b0;
      if (w_sample) r_prev_line <= w_line;
      if (w_sync_enter) begin
        r_status   <= c_STATUS_RX;
        r_err      <= c_ERR_NONE;
        r_cnt      <= c_CNT_W'(1);
        r_ones     <= '0;
        r_eop_seen <= 1'b0;
      end
      // The closing SYNC 1 counts toward the stuffing run
      if (w_sync_bit) begin
        r_cnt  <= r_cnt + 1'b1;
        r_ones <= w_bit ? r_ones + 1'b1 : '0;
      end
      if (w_data_enter) r_cnt <= '0;
      if (w_bit_take) begin
        r_shift <= {w_bit, r_shift[DATA_W-1:1]};
        r_ones  <= w_bit ? r_ones + 1'b1 : '0;
        if (r_cnt == c_CNT_LAST) begin
          r_cnt  <= '0;
          r_push <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_stuff_skip) r_ones <= '0;
      if (w_eop_hit) begin
        r_eop      <= 1'b1;
        r_eop_seen <= 1'b1;
        if (r_cnt != '0) begin
          r_status <= c_STATUS_ERR;
          r_err    <= c_ERR_FRAME;
        end else begin
          r_status <= c_STATUS_OK;
        end
      end
      if (w_err_hit) begin
        r_status <= c_STATUS_ERR;
        r_err    <= w_err_val;
      end
      if (w_fifo_ovf) r_err <= c_ERR_OVF;
    end
  end

  assign w_pop = ~w_empty & data_ready;

  usb_rx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (w_flush),
    .push     (r_push),
    .push_data(r_shift),
    .pop      (w_pop),
    .pop_data (data_out),
    .full     (w_full),
    .empty    (w_empty),
    .overflow (w_fifo_ovf)
  );

  assign data_valid = ~w_empty;
  assign status     = r_status;
  assign err_code   = r_err;
  assign eop        = r_eop;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_decoder
// Brief    : Directed vectors for usb_rx_decoder (8-bit and 16-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_decoder;

  localparam logic [1:0] c_J   = 2'b10;
  localparam logic [1:0] c_K   = 2'b01;
  localparam logic [1:0] c_SE0 = 2'b00;
  localparam logic [1:0] c_SE1 = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d_p = 1'b1, d_n = 1'b0, vbus = 1'b1, rx_en = 1'b1;
  logic rdy8 = 1'b0, rdy16 = 1'b0;
  logic [7:0]  data_out8;
  logic [15:0] data_out16;
  logic valid8, valid16, eop8, eop16;
  logic [1:0] status8, status16, err8, err16;

  int n_checks = 0;
  int n_fail   = 0;
  int eop_cnt8 = 0;
  int e0;
  logic [1:0] lvl = 2'b10;
  int ones = 0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_data;
    logic [1:0] exp_status;
    logic [1:0] exp_err;
    logic [3:0] exp_eops;
  } vec_t;
  vec_t vecs[5];
  logic [7:0] burst[5];

  usb_rx_decoder #(.OVERSAMPLE(4), .DATA_W(8), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .d_p(d_p), .d_n(d_n), .vbus(vbus), .rx_en(rx_en),
    .data_out(data_out8), .data_valid(valid8), .data_ready(rdy8),
    .status(status8), .err_code(err8), .eop(eop8)
  );

  usb_rx_decoder #(.OVERSAMPLE(4), .DATA_W(16), .FIFO_DEPTH(4)) dut16 (
    .clk(clk), .rst(rst), .d_p(d_p), .d_n(d_n), .vbus(vbus), .rx_en(rx_en),
    .data_out(data_out16), .data_valid(valid16), .data_ready(rdy16),
    .status(status16), .err_code(err16), .eop(eop16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (eop8) eop_cnt8 <= eop_cnt8 + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_sym(input logic [1:0] s);
    {d_p, d_n} = s;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_raw(input logic b);
    if (!b) lvl = (lvl == c_J) ? c_K : c_J;
    drive_sym(lvl);
  endtask

  task automatic send_bit(input logic b);
    send_raw(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      send_raw(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_idle(input int n);
    lvl  = c_J;
    ones = 0;
    repeat (n) drive_sym(c_J);
  endtask

  task automatic send_sync();
    lvl = c_J;
    repeat (7) send_raw(1'b0);
    send_raw(1'b1);
    ones = 1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_eop();
    drive_sym(c_SE0);
    drive_sym(c_SE0);
    send_idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    send_idle(4);
  endtask

  task automatic pop8();
    rdy8 = 1'b1;
    @(negedge clk);
    rdy8 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 2'b10, 2'b00, 4'd1};
    vecs[1] = '{8'h00, 8'h00, 2'b10, 2'b00, 4'd1};
    vecs[2] = '{8'hFF, 8'hFF, 2'b10, 2'b00, 4'd1};
    vecs[3] = '{8'h3C, 8'h3C, 2'b10, 2'b00, 4'd1};
    vecs[4] = '{8'h81, 8'h81, 2'b10, 2'b00, 4'd1};
    burst   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out8), 0);
    check("rst_valid", 32'(valid8), 0);
    check("rst_status", 32'(status8), 0);
    check("rst_err", 32'(err8), 0);
    check("rst_eop", 32'(eop8), 0);
    rst = 1'b1;
    send_idle(4);

    // Single-byte packets from the table
    for (int i = 0; i < 5; i++) begin
      e0 = eop_cnt8;
      send_sync();
      send_byte(vecs[i].tx);
      send_eop();
      check("pkt_valid", 32'(valid8), 1);
      check("pkt_data", 32'(data_out8), 32'(vecs[i].exp_data));
      check("pkt_status", 32'(status8), 32'(vecs[i].exp_status));
      check("pkt_err", 32'(err8), 32'(vecs[i].exp_err));
      check("pkt_eops", 32'(eop_cnt8 - e0), 32'(vecs[i].exp_eops));
      pop8();
      check("pkt_drained", 32'(valid8), 0);
    end

    // 16-bit word with stuff bits in the stream
    do_reset();
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h7F);
    send_eop();
    check("w16_valid", 32'(valid16), 1);
    check("w16_data", 32'(data_out16), 32'h7FFF);
    check("w16_status", 32'(status16), 2);
    check("w16_err", 32'(err16), 0);
    rdy16 = 1'b1;
    @(negedge clk);
    rdy16 = 1'b0;
    check("w16_single", 32'(valid16), 0);

    // Seven ones with no stuff bit
    do_reset();
    e0 = eop_cnt8;
    send_sync();
    repeat (7) send_raw(1'b1);
    send_idle(3);
    check("stuff_status", 32'(status8), 3);
    check("stuff_err", 32'(err8), 1);
    check("stuff_nopush", 32'(valid8), 0);
    check("stuff_noeop", 32'(eop_cnt8 - e0), 0);

    // Five bytes into a four-deep FIFO
    do_reset();
    send_sync();
    for (int i = 0; i < 5; i++) send_byte(burst[i]);
    send_eop();
    check("ovf_err", 32'(err8), 2);
    check("ovf_valid", 32'(valid8), 1);
    rdy8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_valid", 32'(valid8), 1);
      check("ovf_drain_data", 32'(data_out8), 32'(burst[i]));
      @(negedge clk);
    end
    rdy8 = 1'b0;
    check("ovf_drained", 32'(valid8), 0);

    // SE1 in the middle of a byte, then a clean packet
    do_reset();
    send_sync();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    drive_sym(c_SE1);
    send_idle(3);
    check("se1_status", 32'(status8), 3);
    check("se1_err", 32'(err8), 3);
    check("se1_nopush", 32'(valid8), 0);
    send_sync();
    send_byte(8'h5A);
    send_eop();
    check("se1_rec_status", 32'(status8), 2);
    check("se1_rec_err", 32'(err8), 0);
    check("se1_rec_data", 32'(data_out8), 32'h5A);
    pop8();

    // Reset asserted mid-packet
    send_sync();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_valid", 32'(valid8), 0);
    check("mrst_status", 32'(status8), 0);
    check("mrst_data_out", 32'(data_out8), 0);
    rst = 1'b1;
    send_idle(4);
    e0 = eop_cnt8;
    send_sync();
    send_byte(8'hC3);
    send_eop();
    check("mrst_rec_data", 32'(data_out8), 32'hC3);
    check("mrst_rec_status", 32'(status8), 2);
    check("mrst_rec_eops", 32'(eop_cnt8 - e0), 1);

    // vbus drop mid-packet with a word still held
    send_sync();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    vbus = 1'b0;
    repeat (4) @(negedge clk);
    check("vbus_valid", 32'(valid8), 0);
    check("vbus_status", 32'(status8), 0);
    vbus = 1'b1;
    send_idle(4);
    send_sync();
    send_byte(8'h69);
    send_eop();
    check("vbus_rec_valid", 32'(valid8), 1);
    check("vbus_rec_data", 32'(data_out8), 32'h69);
    check("vbus_rec_status", 32'(status8), 2);
    pop8();
    check("vbus_rec_single", 32'(valid8), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
